// File: rtl/regfile_write_arbiter_pkg.sv
// Shared constants and types for the register-file write path.
// The zero register is hardwired and never written or tracked.
package regfile_write_arbiter_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    GRANT_REQ0 = 1'b0,
    GRANT_REQ1 = 1'b1
  } grant_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write.
// Set wins over clear on the same register in the same cycle.
module regfile_scoreboard
  import regfile_write_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_valid,
  input  logic [REG_ADDR_W-1:0] set_rd,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_rd,
  input  logic [REG_ADDR_W-1:0] ra,
  input  logic [REG_ADDR_W-1:0] rb,
  output logic                  stall,
  output logic                  issue_err
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  always_comb begin
    pending_d = pending_q;
    if (clr_valid && clr_rd != ZERO_REG) pending_d[clr_rd] = 1'b0;
    if (set_valid && set_rd != ZERO_REG) pending_d[set_rd] = 1'b1;
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Both lookups use the registered state, so a clear shows up one cycle late.
  assign stall     = pending_q[ra] | pending_q[rb];
  assign issue_err = set_valid && (set_rd != ZERO_REG) && pending_q[set_rd];

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port,
// with a pending-write scoreboard for decode stall detection.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
(
  input  logic                  Clk,
  input  logic                  resetl,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_rw,
  input  logic [DATA_W-1:0]     req0_data,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_rw,
  input  logic [DATA_W-1:0]     req1_data,
  output logic                  req0_ready,
  output logic                  req1_ready,
  output logic                  RegWr,
  output logic [REG_ADDR_W-1:0] RW,
  output logic [DATA_W-1:0]     BusW,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] RA,
  input  logic [REG_ADDR_W-1:0] RB,
  output logic                  stall,
  output logic                  issue_err
);

  grant_e                last_grant;
  logic                  accept;
  logic [REG_ADDR_W-1:0] sel_rw;
  logic [DATA_W-1:0]     sel_data;

  // On contention, the requester that did not win last time goes first.
  assign req0_ready = resetl && req0_valid && (!req1_valid || last_grant == GRANT_REQ1);
  assign req1_ready = resetl && req1_valid && (!req0_valid || last_grant == GRANT_REQ0);
  assign accept     = req0_ready | req1_ready;
  assign sel_rw     = req1_ready ? req1_rw   : req0_rw;
  assign sel_data   = req1_ready ? req1_data : req0_data;

  always_ff @(posedge Clk or negedge resetl) begin
    if (!resetl) begin
      last_grant <= GRANT_REQ1;
      RegWr      <= 1'b0;
      RW         <= '0;
      BusW       <= '0;
    end else if (accept) begin
      last_grant <= req1_ready ? GRANT_REQ1 : GRANT_REQ0;
      RegWr      <= (sel_rw != ZERO_REG);
      RW         <= sel_rw;
      BusW       <= sel_data;
    end else begin
      RegWr      <= 1'b0;
    end
  end

  regfile_scoreboard u_scoreboard (
    .clk       (Clk),
    .rst_n     (resetl),
    .set_valid (issue_valid),
    .set_rd    (issue_rd),
    .clr_valid (accept),
    .clr_rd    (sel_rw),
    .ra        (RA),
    .rb        (RB),
    .stall     (stall),
    .issue_err (issue_err)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        resetl = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [4:0]  req0_rw = '0, req1_rw = '0;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic        req0_ready, req1_ready;
  logic        RegWr;
  logic [4:0]  RW;
  logic [31:0] BusW;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [4:0]  RA = '0, RB = '0;
  logic        stall, issue_err;

  int checks = 0;
  int errors = 0;

  regfile_write_arbiter dut (
    .Clk(Clk), .resetl(resetl),
    .req0_valid(req0_valid), .req0_rw(req0_rw), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_rw(req1_rw), .req1_data(req1_data),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .RegWr(RegWr), .RW(RW), .BusW(BusW),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .RA(RA), .RB(RB), .stall(stall), .issue_err(issue_err)
  );

  always #5 Clk = ~Clk;

  // Behavioural model: a set of pending registers, who won last, and the write port.
  bit          pend [32];
  int          m_last = 1;
  bit          m_regwr = 0;
  bit [4:0]    m_rw = 0;
  bit [31:0]   m_busw = 0;

  function automatic int winner(bit v0, bit v1, int last);
    if (v0 && v1) return (last == 0) ? 1 : 0;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    foreach (pend[i]) pend[i] = 0;
    m_last = 1; m_regwr = 0; m_rw = 0; m_busw = 0;
  endtask

  always @(negedge resetl) model_reset();

  always @(posedge Clk) begin
    if (resetl) begin
      int w;
      w = winner(req0_valid, req1_valid, m_last);
      if (w >= 0) begin
        m_last  = w;
        m_rw    = (w == 0) ? req0_rw : req1_rw;
        m_busw  = (w == 0) ? req0_data : req1_data;
        m_regwr = (m_rw != 0);
        pend[m_rw] = 0;
      end else begin
        m_regwr = 0;
      end
      if (issue_valid && issue_rd != 0) pend[issue_rd] = 1;
      pend[0] = 0;
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Single per-cycle compare against the model.
  always @(negedge Clk) begin
    int w;
    bit e_r0, e_r1, e_err;
    w     = resetl ? winner(req0_valid, req1_valid, m_last) : -1;
    e_r0  = (w == 0);
    e_r1  = (w == 1);
    e_err = resetl && issue_valid && issue_rd != 0 && pend[issue_rd];
    chk("model_ready0", {31'b0, req0_ready}, {31'b0, e_r0});
    chk("model_ready1", {31'b0, req1_ready}, {31'b0, e_r1});
    chk("model_regwr",  {31'b0, RegWr}, {31'b0, m_regwr});
    chk("model_rw",     {27'b0, RW}, {27'b0, m_rw});
    chk("model_busw",   BusW, m_busw);
    chk("model_stall",  {31'b0, stall}, {31'b0, (pend[RA] || pend[RB])});
    chk("model_err",    {31'b0, issue_err}, {31'b0, e_err});
  end

  task automatic next_cycle();
    @(posedge Clk); #1;
  endtask

  task automatic mid_cycle();
    @(negedge Clk); #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; issue_valid = 0;
  endtask

  task automatic do_reset();
    resetl = 1'b0;
    idle_inputs();
    repeat (2) @(posedge Clk);
    #1 resetl = 1'b1;
  endtask

  int grants [4];

  initial begin
    do_reset();
    mid_cycle();
    chk("reset_regwr", {31'b0, RegWr}, 32'd0);
    chk("reset_rw", {27'b0, RW}, 32'd0);
    chk("reset_busw", BusW, 32'd0);

    // Single write, one-cycle latency
    next_cycle();
    req0_valid = 1; req0_rw = 5; req0_data = 32'h1234;
    mid_cycle();
    chk("single_ready0", {31'b0, req0_ready}, 32'd1);
    next_cycle();
    req0_valid = 0;
    mid_cycle();
    chk("single_regwr", {31'b0, RegWr}, 32'd1);
    chk("single_rw", {27'b0, RW}, 32'd5);
    chk("single_busw", BusW, 32'h1234);
    next_cycle();
    mid_cycle();
    chk("single_regwr_drop", {31'b0, RegWr}, 32'd0);

    // Round robin under contention
    do_reset();
    req0_valid = 1; req0_rw = 1; req0_data = 32'hA;
    req1_valid = 1; req1_rw = 2; req1_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      mid_cycle();
      chk("rr_one_ready", {31'b0, req0_ready ^ req1_ready}, 32'd1);
      grants[i] = req1_ready ? 1 : 0;
      next_cycle();
    end
    idle_inputs();
    chk("rr_g0", grants[0], 0);
    chk("rr_g1", grants[1], 1);
    chk("rr_g2", grants[2], 0);
    chk("rr_g3", grants[3], 1);

    // Write to register zero is consumed but does not write
    req1_valid = 1; req1_rw = 0; req1_data = 32'hFFFF;
    mid_cycle();
    chk("zero_ready1", {31'b0, req1_ready}, 32'd1);
    next_cycle();
    req1_valid = 0;
    mid_cycle();
    chk("zero_regwr", {31'b0, RegWr}, 32'd0);
    chk("zero_busw", BusW, 32'hFFFF);

    // Scoreboard stall, clear and set-over-clear
    next_cycle();
    issue_valid = 1; issue_rd = 7;
    next_cycle();
    issue_valid = 0; RA = 7; RB = 0;
    mid_cycle();
    chk("sb_stall_set", {31'b0, stall}, 32'd1);
    next_cycle();
    req0_valid = 1; req0_rw = 7; req0_data = 32'h77;
    mid_cycle();
    chk("sb_stall_before_clear", {31'b0, stall}, 32'd1);
    next_cycle();
    req0_valid = 0;
    mid_cycle();
    chk("sb_stall_cleared", {31'b0, stall}, 32'd0);
    next_cycle();
    req0_valid = 1; req0_rw = 7; issue_valid = 1; issue_rd = 7;
    mid_cycle();
    chk("sb_same_cycle_noerr", {31'b0, issue_err}, 32'd0);
    next_cycle();
    idle_inputs();
    mid_cycle();
    chk("sb_set_wins", {31'b0, stall}, 32'd1);

    // Double issue error and register zero
    next_cycle();
    issue_valid = 1; issue_rd = 9;
    mid_cycle();
    chk("err_first_issue", {31'b0, issue_err}, 32'd0);
    next_cycle();
    mid_cycle();
    chk("err_second_issue", {31'b0, issue_err}, 32'd1);
    next_cycle();
    issue_rd = 0; RA = 0; RB = 0;
    mid_cycle();
    chk("err_rd0", {31'b0, issue_err}, 32'd0);
    next_cycle();
    issue_valid = 0;
    mid_cycle();
    chk("stall_rd0", {31'b0, stall}, 32'd0);

    // Reset between accept and write
    next_cycle();
    req1_valid = 1; req1_rw = 3; req1_data = 32'hAB;
    next_cycle();
    resetl = 0;
    #1;
    chk("rst_regwr_forced", {31'b0, RegWr}, 32'd0);
    chk("rst_ready1_forced", {31'b0, req1_ready}, 32'd0);
    idle_inputs();
    next_cycle();
    resetl = 1;
    mid_cycle();
    chk("rst_no_regwr", {31'b0, RegWr}, 32'd0);
    RA = 9; RB = 7;
    #1 chk("rst_pending_cleared", {31'b0, stall}, 32'd0);
    next_cycle();
    req0_valid = 1; req1_valid = 1; req0_rw = 4; req1_rw = 6;
    mid_cycle();
    chk("rst_last_grant", {30'b0, req1_ready, req0_ready}, 32'd1);
    next_cycle();
    idle_inputs();

    // Randomized traffic, model comparison on every negedge
    for (int n = 0; n < 3000; n++) begin
      req0_valid  = ($urandom_range(0, 99) < 50);
      req1_valid  = ($urandom_range(0, 99) < 50);
      req0_rw     = 5'($urandom_range(0, 31));
      req1_rw     = 5'($urandom_range(0, 31));
      req0_data   = $urandom;
      req1_data   = $urandom;
      issue_valid = ($urandom_range(0, 99) < 40);
      issue_rd    = 5'($urandom_range(0, 31));
      RA          = 5'($urandom_range(0, 31));
      RB          = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 299) == 0) begin
        resetl = 0;
        next_cycle();
        resetl = 1;
      end else begin
        next_cycle();
      end
    end
    idle_inputs();
    mid_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
